// File: rtl/fetch_queue.sv
// fetch_queue: {pc, instr} FIFO between fetch and decode.
// Stalls the PC when full; a redirect flushes everything.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              f_pc,
  input  logic [31:0]              f_instr,
  input  logic                     f_valid,
  input  logic                     flush,
  output logic                     pc_stall,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [31:0]              d_pc,
  output logic [31:0]              d_pc8,
  output logic [31:0]              d_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Status and handshake qualifiers, all from registered count.
  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    pc_stall = full;
    d_valid  = !empty;
    push     = f_valid & !full & !flush;
    pop      = !empty & d_ready & !flush;
  end

  // Pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are never reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wr_ptr]    <= f_pc;
      instr_mem[wr_ptr] <= f_instr;
    end
  end

  // Head entry view; an empty queue presents a zero bubble.
  always_comb begin
    d_pc    = 32'h0;
    d_pc8   = 32'h0;
    d_instr = 32'h0;
    if (!empty) begin
      d_pc    = pc_mem[rd_ptr];
      d_pc8   = pc_mem[rd_ptr] + 32'd8;
      d_instr = instr_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of the fetch/decode FIFO.
// Covers latency, full stall, flush, wrap and reset.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_valid;
  logic        flush;
  logic        pc_stall;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic [31:0] d_instr;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [31:0] q_pc[$];

  fetch_queue #(.DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .f_pc     (f_pc),
    .f_instr  (f_instr),
    .f_valid  (f_valid),
    .flush    (flush),
    .pc_stall (pc_stall),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_pc     (d_pc),
    .d_pc8    (d_pc8),
    .d_instr  (d_instr),
    .count    (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fi(input logic [31:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic fl, input logic rdy);
    f_valid = v;
    f_pc    = pc;
    f_instr = fi(pc);
    flush   = fl;
    d_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] pc,
                      input logic [2:0] cnt);
    chk({tag, "_valid"}, 32'(d_valid), 32'(cnt != 0));
    chk({tag, "_pc"},    d_pc,    pc);
    chk({tag, "_pc8"},   d_pc8,   pc + 32'd8);
    chk({tag, "_instr"}, d_instr, fi(pc));
    chk({tag, "_count"}, 32'(count), 32'(cnt));
    chk({tag, "_stall"}, 32'(pc_stall), 32'(cnt == 3'd4));
  endtask

  task automatic idle(input string tag);
    chk({tag, "_valid"}, 32'(d_valid), 32'd0);
    chk({tag, "_pc"},    d_pc,    32'h0);
    chk({tag, "_pc8"},   d_pc8,   32'h0);
    chk({tag, "_instr"}, d_instr, 32'h0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_stall"}, 32'(pc_stall), 32'd0);
  endtask

  // Occupancy bound every cycle (also catches underflow wrap).
  always @(negedge clk) begin
    if (mon_en) chk("count_bound", 32'(count <= 3'd4), 32'd1);
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    idle("reset");

    // streaming with decode always ready
    drive(1'b1, 32'h3000, 1'b0, 1'b1);
    tick();
    head("s0", 32'h3000, 3'd1);
    drive(1'b1, 32'h3004, 1'b0, 1'b1);
    tick();
    head("s1", 32'h3004, 3'd1);
    drive(1'b1, 32'h3008, 1'b0, 1'b1);
    tick();
    head("s2", 32'h3008, 3'd1);
    chk("s2_pc8_abs", d_pc8, 32'h3010);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    idle("s_drain");

    // fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3000 + 32'(4*i), 1'b0, 1'b0);
      tick();
      head($sformatf("fill%0d", i), 32'h3000, 3'(i+1));
    end
    drive(1'b1, 32'h3010, 1'b0, 1'b0);
    tick();
    head("full_hold", 32'h3000, 3'd4);
    // full + pop: push rejected
    drive(1'b1, 32'h3010, 1'b0, 1'b1);
    tick();
    head("full_pop", 32'h3004, 3'd3);
    // re-presented pair accepted alongside a pop
    tick();
    head("push_pop", 32'h3008, 3'd3);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    head("dr0", 32'h300C, 3'd2);
    tick();
    head("dr1", 32'h3010, 3'd1);
    tick();
    idle("dr_end");

    // flush with three queued, fetch and pop attempted
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h5000 + 32'(4*i), 1'b0, 1'b0);
      tick();
    end
    head("pre_flush", 32'h5000, 3'd3);
    drive(1'b1, 32'h500C, 1'b1, 1'b1);
    tick();
    idle("flush");
    drive(1'b1, 32'h4000, 1'b0, 1'b0);
    tick();
    head("post_flush", 32'h4000, 3'd1);
    // flush while full drops the stall
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h4004 + 32'(4*i), 1'b0, 1'b0);
      tick();
    end
    head("full2", 32'h4000, 3'd4);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    idle("flush_full");

    // wrap-around with interleaved stalls, scoreboard ordering
    begin
      int idx = 0;
      bit seen_wrap = 0;
      for (int c = 0; c < 60; c++) begin
        logic        fv, rdy;
        logic [31:0] pc;
        bit          psh, pp;
        pc  = (idx < 9) ? 32'h6000 + 32'(4*idx) : 32'hFFFF_FFF8;
        fv  = (idx < 10);
        rdy = (c >= 3 && c <= 8) ? 1'b0 : (c % 3 != 0);
        drive(fv, pc, 1'b0, rdy);
        chk("wr_count", 32'(count), 32'(q_pc.size()));
        if (q_pc.size() != 0) begin
          chk("wr_pc",    d_pc,    q_pc[0]);
          chk("wr_instr", d_instr, fi(q_pc[0]));
          if (q_pc[0] == 32'hFFFF_FFF8) begin
            chk("wr_pc8_wrap", d_pc8, 32'h0000_0000);
            seen_wrap = 1;
          end
        end else begin
          chk("wr_empty", 32'(d_valid), 32'd0);
        end
        psh = fv && (q_pc.size() < 4);
        pp  = rdy && (q_pc.size() > 0);
        tick();
        if (pp) void'(q_pc.pop_front());
        if (psh) begin
          q_pc.push_back(pc);
          idx++;
        end
        if (idx == 10 && q_pc.size() == 0) break;
      end
      chk("wr_all_pushed", 32'(idx), 32'd10);
      chk("wr_all_popped", 32'(q_pc.size()), 32'd0);
      chk("wr_pc8_seen", 32'(seen_wrap), 32'd1);
    end

    // reset mid-stream
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h7000 + 32'(4*i), 1'b0, 1'b0);
      tick();
    end
    head("pre_reset", 32'h7000, 3'd2);
    drive(1'b1, 32'h7008, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    idle("mid_reset");
    tick();
    idle("mid_reset2");

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between the fetch stage (PC register plus combinational instruction memory read) and the decode stage.
- Each valid fetch slot pushes a {pc, instr} pair into a DEPTH-entry FIFO. Decode pops pairs with a valid/ready handshake.
- When the FIFO is full, the block raises pc_stall to freeze the PC register.
- A redirect (branch/jump taken) flushes all buffered entries and drops the fetch in flight.

Parameters:
- DEPTH, 4, number of {pc, instr} entries. Must be a power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- f_pc  input  32  PC of the current fetch slot, driven by the PC register
- f_instr  input  32  instruction word read from IM at f_pc, same cycle
- f_valid  input  1  current fetch slot holds a real instruction
- flush  input  1  redirect: discard queue contents and the current fetch slot
- pc_stall  output  1  to PC stall input; high when the queue is full
- d_valid  output  1  head entry present
- d_ready  input  1  decode accepts the head entry this cycle
- d_pc  output  32  PC of the head entry
- d_pc8  output  32  d_pc + 8, wraps mod 2^32
- d_instr  output  32  instruction of the head entry
- count  output  log2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage: circular buffer with write pointer, read pointer and occupancy counter, all registered.
- Reset (reset=1 at a rising edge): count=0, pointers=0, d_valid=0, pc_stall=0. Entry RAM contents are not reset.
- Definitions:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - pc_stall = full, combinational from registered count only. It must not depend on d_ready or flush.
  - push = f_valid & !full & !flush
  - pop = d_valid & d_ready & !flush
- d_valid = !empty.
- While empty, d_pc, d_pc8 and d_instr are forced to 32'h0000_0000. Decode therefore sees a nop bubble, and a d_ready pop is ignored.
- When not empty, d_pc, d_pc8 and d_instr present the head entry combinationally from registered storage. d_pc8 is d_pc + 8, truncated to 32 bits.
- Latency: a pair pushed at edge N is visible on d_* after edge N (one-cycle fall-through minimum). There is no same-cycle bypass from f_* to d_*.
- Push only: write {f_pc, f_instr} at wr_ptr, advance wr_ptr, count+1.
- Pop only: advance rd_ptr, count-1.
- Push and pop in the same cycle (queue neither full nor empty): both pointers advance, count unchanged.
- Full and pop in the same cycle: push is rejected because pc_stall was high. count-1, and pc_stall drops the next cycle.
  - f_valid with full is not an error. The PC is held, so the same f_pc is re-presented next cycle.
- Empty, push and d_ready in the same cycle: no pop; the entry is delivered next cycle.
- Pointer wrap-around at DEPTH-1 → 0 is seamless; ordering is strictly FIFO.
- Flush (flush=1 at an edge, reset=0):
  - pointers=0, count=0.
  - The current f_* slot is not written, and no pop is counted.
  - The next cycle has d_valid=0 and pc_stall=0.
  - Flush takes priority over push and pop. Reset takes priority over flush.
- Reset or flush mid-stream discards all entries. No partial state survives.
- count never exceeds DEPTH and never underflows. The bench asserts both every cycle.

Test Plan:
- Reset, then f_valid=1 with f_pc=0x3000, 0x3004, 0x3008 on consecutive cycles, d_ready=1 → d_pc sequence 0x3000, 0x3004, 0x3008 one cycle after each push; d_pc8 = 0x3008, 0x300C, 0x3010; count stays ≤1.
- d_ready=0, push 5 pairs (f_pc 0x3000–0x3010) with DEPTH=4 → count reaches 4 and pc_stall=1 on the cycle after the 4th push. 5th pair (0x3010) not written. Then d_ready=1 → pops 0x3000..0x300C in order, pc_stall falls after the first pop, 0x3010 accepted on re-presentation.
- Full queue, d_ready=1 and f_valid=1 together → count 4→3, no write that cycle; next cycle push plus pop keeps count=3.
- Three entries queued, flush=1 with f_valid=1 and d_ready=1 → next cycle count=0, d_valid=0, d_instr=0, pc_stall=0. A push of f_pc=0x4000 the following cycle is the next d_pc.
- 10 push/pop pairs with interleaved d_ready stalls → pointers wrap past 3→0 and the output order matches the input order exactly; f_pc=0xFFFF_FFF8 gives d_pc8=0x0000_0000.
- Assert reset with 2 entries queued and flush=0 → next cycle count=0, d_valid=0, d_pc=0, pc_stall=0.
